// File: rtl/spi_wr_pkg.sv
// Shared types and constants for the SPI frame writer: FSM state encoding,
// default geometry and the bit-counter width helper.
package spi_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DATA_WL_DEF  = 28;
  localparam int FRAME_WL_DEF = 32;
  localparam int DEPTH_DEF    = 36;

  // Width of a counter indexing 0..frame_wl-1; never narrower than one bit.
  function automatic int bit_cnt_wl(input int frame_wl);
    return (frame_wl > 1) ? $clog2(frame_wl) : 1;
  endfunction

endpackage

// File: rtl/spi_shift_deser.sv
// Serial-to-parallel core: shift register, frame bit counter and word-ready pulse.
// Optional parity check on frame bit DATA_WL when SPI_FRAME_WRITER_PARITY_EN is defined.
module spi_shift_deser
  import spi_wr_pkg::*;
#(
  parameter int DATA_WL   = DATA_WL_DEF,
  parameter int FRAME_WL  = FRAME_WL_DEF,
  parameter int LSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               start,
  input  logic               take,
  input  logic               mosi,
  output logic               word_hit,
  output logic               word_rdy,
  output logic [DATA_WL-1:0] word
`ifdef SPI_FRAME_WRITER_PARITY_EN
  ,
  output logic               par_err
`endif
);

  localparam int CNT_WL = bit_cnt_wl(FRAME_WL);

  logic [CNT_WL-1:0]  cnt;
  logic [CNT_WL-1:0]  cnt_base;
  logic [CNT_WL-1:0]  cnt_next;
  logic [DATA_WL-1:0] sr;
  logic [DATA_WL-1:0] sr_next;

`ifdef SPI_FRAME_WRITER_PARITY_EN
  logic par_next;

  // Even parity: the check bit equals the XOR of all data bits.
  function automatic logic even_par(input logic [DATA_WL-1:0] w);
    return ^w;
  endfunction
`endif

  // Next counter/shift values; a start discards the partial frame so a coincident bit is index 0.
  always_comb begin
    cnt_base = start ? '0 : cnt;
    cnt_next = cnt_base;
    sr_next  = sr;
    word_hit = take && (int'(cnt_base) == DATA_WL - 1);
    if (take) begin
      if (int'(cnt_base) == FRAME_WL - 1) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_base + CNT_WL'(1);
      end
      if (int'(cnt_base) < DATA_WL) begin
        if (LSB_FIRST != 0) begin
          sr_next = {mosi, sr[DATA_WL-1:1]};
        end else begin
          sr_next = {sr[DATA_WL-2:0], mosi};
        end
      end else begin
        sr_next = sr;
      end
    end else begin
      cnt_next = cnt_base;
    end
  end

`ifdef SPI_FRAME_WRITER_PARITY_EN
  // Sticky parity flag; the word under test was latched when its last data bit arrived.
  always_comb begin
    par_next = start ? 1'b0 : par_err;
    if (take && (int'(cnt_base) == DATA_WL) && (mosi != even_par(word))) begin
      par_next = 1'b1;
    end else begin
      par_next = par_next;
    end
  end
`endif

  // Shift state and the registered word/ready outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sr       <= '0;
      word     <= '0;
      word_rdy <= 1'b0;
`ifdef SPI_FRAME_WRITER_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else if (clr) begin
      cnt      <= '0;
      sr       <= '0;
      word     <= '0;
      word_rdy <= 1'b0;
`ifdef SPI_FRAME_WRITER_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      cnt      <= cnt_next;
      sr       <= sr_next;
      word_rdy <= word_hit;
      if (word_hit) begin
        word <= sr_next;
      end
`ifdef SPI_FRAME_WRITER_PARITY_EN
      par_err  <= par_next;
`endif
    end
  end

endmodule

// File: rtl/spi_frame_writer.sv
// SPI frame writer top: FSM, saturating write address and done-delay counter.
// Optional parity checking is enabled with the macro SPI_FRAME_WRITER_PARITY_EN.
module spi_frame_writer
  import spi_wr_pkg::*;
#(
  parameter int DATA_WL   = DATA_WL_DEF,
  parameter int FRAME_WL  = FRAME_WL_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_WL   = 6,
  parameter int DONE_DLY  = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iCLR,
  input  logic               iSTART,
  input  logic               iEN,
  input  logic               iMOSI,
  output logic [DATA_WL-1:0] oDATA,
  output logic               oWr_EN,
  output logic [ADDR_WL-1:0] oWr_ADDR,
  output logic               oWr_DONE,
  output logic               oBUSY
`ifdef SPI_FRAME_WRITER_PARITY_EN
  ,
  output logic               oPAR_ERR
`endif
);

  localparam int                 FL_WL   = $clog2(DONE_DLY + 2);
  localparam logic [ADDR_WL-1:0] LAST    = ADDR_WL'(DEPTH - 1);
  localparam logic [FL_WL-1:0]   FL_DONE = FL_WL'(DONE_DLY);
  localparam logic [FL_WL-1:0]   FL_END  = FL_WL'(DONE_DLY + 1);

  state_t             state;
  state_t             state_n;
  state_t             st_base;
  logic [ADDR_WL-1:0] addr;
  logic [ADDR_WL-1:0] addr_n;
  logic [FL_WL-1:0]   flush;
  logic [FL_WL-1:0]   flush_n;
  logic               done;
  logic               done_n;
  logic               take;
  logic               word_hit;

  // Bits count only while receiving, or when a start makes them the first bit of a new image.
  assign take = iEN && ((state == RECV) || iSTART);

  spi_shift_deser #(
    .DATA_WL  (DATA_WL),
    .FRAME_WL (FRAME_WL),
    .LSB_FIRST(LSB_FIRST)
  ) u_deser (
    .clk     (iCLK),
    .rst_n   (iRSTn),
    .clr     (iCLR),
    .start   (iSTART),
    .take    (take),
    .mosi    (iMOSI),
    .word_hit(word_hit),
    .word_rdy(oWr_EN),
    .word    (oDATA)
`ifdef SPI_FRAME_WRITER_PARITY_EN
    ,
    .par_err (oPAR_ERR)
`endif
  );

  // Next state, address and flush timing; a start behaves like entering RECV from scratch.
  always_comb begin
    state_n = state;
    flush_n = '0;
    done_n  = 1'b0;
    st_base = state;
    addr_n  = addr;
    if (iSTART) begin
      st_base = RECV;
      addr_n  = '0;
    end else if (oWr_EN && (addr != LAST)) begin
      addr_n = addr + ADDR_WL'(1);
    end else begin
      addr_n = addr;
    end
    case (st_base)
      IDLE: begin
        state_n = IDLE;
      end
      RECV: begin
        if (word_hit && (addr_n == LAST)) begin
          state_n = FLUSH;
        end else begin
          state_n = RECV;
        end
      end
      FLUSH: begin
        if (flush == FL_END) begin
          state_n = IDLE;
        end else begin
          state_n = FLUSH;
          flush_n = flush + FL_WL'(1);
          done_n  = (flush == FL_DONE);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
      addr  <= '0;
      flush <= '0;
      done  <= 1'b0;
    end else if (iCLR) begin
      state <= IDLE;
      addr  <= '0;
      flush <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      flush <= flush_n;
      done  <= done_n;
    end
  end

  assign oWr_ADDR = addr;
  assign oWr_DONE = done;
  assign oBUSY    = (state != IDLE);

endmodule

// File: tb/tb_spi_frame_writer.sv
// Directed self-checking bench for spi_frame_writer (default and LSB-first instances).
module tb_spi_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        en = 1'b0;
  logic        mosi = 1'b0;
  logic [27:0] data, l_data;
  logic        wr_en, l_wr_en, wr_done, l_done, busy, l_busy;
  logic [5:0]  wr_addr, l_addr;
`ifdef SPI_FRAME_WRITER_PARITY_EN
  logic        par_err, l_par;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_last = 0;
  int          wr_cyc[$];
  logic [5:0]  wr_adr[$];
  logic [27:0] wr_dat[$];
  int          done_cyc[$];

  spi_frame_writer dut (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr), .iSTART(start), .iEN(en), .iMOSI(mosi),
    .oDATA(data), .oWr_EN(wr_en), .oWr_ADDR(wr_addr), .oWr_DONE(wr_done), .oBUSY(busy)
`ifdef SPI_FRAME_WRITER_PARITY_EN
    , .oPAR_ERR(par_err)
`endif
  );

  spi_frame_writer #(.LSB_FIRST(1)) dut_lsb (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr), .iSTART(start), .iEN(en), .iMOSI(mosi),
    .oDATA(l_data), .oWr_EN(l_wr_en), .oWr_ADDR(l_addr), .oWr_DONE(l_done), .oBUSY(l_busy)
`ifdef SPI_FRAME_WRITER_PARITY_EN
    , .oPAR_ERR(l_par)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Event log of the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(wr_addr);
      wr_dat.push_back(data);
    end
    if (wr_done) done_cyc.push_back(cyc);
    if (busy) busy_last = cyc;
  end

  task automatic step(input logic s, input logic e, input logic m);
    start = s; en = e; mosi = m;
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    wr_cyc.delete(); wr_adr.delete(); wr_dat.delete(); done_cyc.delete();
  endtask

  task automatic send_word(input logic [27:0] w, input logic first, input logic [3:0] pad, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      if (i < 28) b = w[27-i];
      else b = pad[31-i];
      step(first && (i == 0), 1'b1, b);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({data, wr_en, wr_addr, wr_done, busy} !== 36'd0) begin
      fails++; $display("FAIL reset_outputs: got %0h required 0", {data, wr_en, wr_addr, wr_done, busy});
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b required 0", busy); end
  endtask

  task automatic test_stream();
    int c0;
    do_clr();
    c0 = cyc;
    for (int f = 0; f < 36; f++) send_word(28'hA5A_0000 + 28'(f), f == 0, 4'h0, 32);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    tests++;
    if (wr_cyc.size() != 36) begin fails++; $display("FAIL stream_count: got %0d required 36", wr_cyc.size()); end
    for (int f = 0; f < 36 && f < wr_cyc.size(); f++) begin
      tests++;
      if (wr_adr[f] !== 6'(f)) begin fails++; $display("FAIL stream_addr[%0d]: got %0d required %0d", f, wr_adr[f], f); end
      tests++;
      if (wr_dat[f] !== 28'hA5A_0000 + 28'(f)) begin
        fails++; $display("FAIL stream_data[%0d]: got %0h required %0h", f, wr_dat[f], 28'hA5A_0000 + 28'(f));
      end
      tests++;
      if (wr_cyc[f] != c0 + 28 + 32 * f) begin
        fails++; $display("FAIL stream_time[%0d]: got %0d required %0d", f, wr_cyc[f], c0 + 28 + 32 * f);
      end
    end
    tests++;
    if (done_cyc.size() != 1) begin fails++; $display("FAIL stream_done_count: got %0d required 1", done_cyc.size()); end
    else begin
      tests++;
      if (done_cyc[0] != c0 + 28 + 35 * 32 + 3) begin
        fails++; $display("FAIL stream_done_time: got %0d required %0d", done_cyc[0], c0 + 28 + 35 * 32 + 3);
      end
    end
    tests++;
    if (busy_last != c0 + 28 + 35 * 32 + 3) begin
      fails++; $display("FAIL stream_busy_fall: got %0d required %0d", busy_last, c0 + 28 + 35 * 32 + 3);
    end
    tests++;
    if (wr_addr !== 6'd35) begin fails++; $display("FAIL stream_addr_sat: got %0d required 35", wr_addr); end
  endtask

  task automatic test_lsb_first();
    logic [27:0] w = 28'h000_0001;
    do_clr();
    for (int i = 0; i < 28; i++) step(i == 0, 1'b1, w[i]);
    tests++;
    if (l_wr_en !== 1'b1 || l_data !== 28'h000_0001 || l_addr !== 6'd0) begin
      fails++; $display("FAIL lsb_write: got en=%0b data=%0h addr=%0d required en=1 data=1 addr=0", l_wr_en, l_data, l_addr);
    end
    tests++;
    if (wr_en !== 1'b1 || data !== 28'h800_0000) begin
      fails++; $display("FAIL msb_same_bits: got en=%0b data=%0h required en=1 data=8000000", wr_en, data);
    end
  endtask

  task automatic test_gapped();
    logic [27:0] w0 = 28'h123_4567;
    logic [27:0] w1 = 28'h0FE_DCBA;
    do_clr();
    for (int i = 0; i < 28; i++) begin
      step(i == 0, 1'b1, w0[27-i]);
      if (i == 27) begin
        tests++;
        if (wr_en !== 1'b1) begin fails++; $display("FAIL gap_wr_timing: got %0b required 1", wr_en); end
      end
      step(1'b0, 1'b0, 1'b1);
      if (i == 27) begin
        tests++;
        if (wr_en !== 1'b0) begin fails++; $display("FAIL gap_wr_pulse: got %0b required 0", wr_en); end
      end
      step(1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end
    tests++;
    if (data !== w0) begin fails++; $display("FAIL gap_pad_data: got %0h required %0h", data, w0); end
    for (int i = 0; i < 28; i++) begin
      step(1'b0, 1'b1, w1[27-i]);
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end
    tests++;
    if (wr_cyc.size() != 2) begin fails++; $display("FAIL gap_count: got %0d required 2", wr_cyc.size()); end
    else begin
      tests++;
      if (wr_adr[1] !== 6'd1 || wr_dat[1] !== w1) begin
        fails++; $display("FAIL gap_second: got addr=%0d data=%0h required addr=1 data=%0h", wr_adr[1], wr_dat[1], w1);
      end
    end
  endtask

  task automatic test_restart();
    do_clr();
    for (int f = 0; f < 10; f++) send_word(28'h111_1000 + 28'(f), f == 0, 4'h0, 32);
    send_word(28'hFFF_FFFF, 1'b0, 4'h0, 5);
    tests++;
    if (wr_cyc.size() != 10 || wr_adr[9] !== 6'd9) begin
      fails++; $display("FAIL restart_pre: got %0d writes required 10 ending at addr 9", wr_cyc.size());
    end
    send_word(28'h9AB_CDEF, 1'b1, 4'h0, 32);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    tests++;
    if (done_cyc.size() != 0) begin fails++; $display("FAIL restart_no_done: got %0d required 0", done_cyc.size()); end
    tests++;
    if (wr_cyc.size() != 11) begin fails++; $display("FAIL restart_count: got %0d required 11", wr_cyc.size()); end
    else begin
      tests++;
      if (wr_adr[10] !== 6'd0 || wr_dat[10] !== 28'h9AB_CDEF) begin
        fails++; $display("FAIL restart_write: got addr=%0d data=%0h required addr=0 data=9abcdef", wr_adr[10], wr_dat[10]);
      end
    end
  endtask

  task automatic test_idle_clr_rst();
    do_clr();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, i[0]);
    tests++;
    if (wr_cyc.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_ignored: got %0d writes busy=%0b required 0 writes busy=0", wr_cyc.size(), busy);
    end
    send_word(28'h0AB_C001, 1'b1, 4'h0, 32);
    send_word(28'h0AB_C002, 1'b0, 4'h0, 32);
    send_word(28'h0AB_C003, 1'b0, 4'h0, 28);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd2 || data !== 28'h0AB_C003) begin
      fails++; $display("FAIL clr_pre: got en=%0b addr=%0d data=%0h required en=1 addr=2 data=abc003", wr_en, wr_addr, data);
    end
    clr = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    clr = 1'b0;
    tests++;
    if ({data, wr_en, wr_addr, wr_done, busy} !== 36'd0) begin
      fails++; $display("FAIL clr_outputs: got %0h required 0", {data, wr_en, wr_addr, wr_done, busy});
    end
    do_clr();
    for (int f = 0; f < 35; f++) send_word(28'h555_0000 + 28'(f), f == 0, 4'h0, 32);
    send_word(28'h555_0023, 1'b0, 4'h0, 28);
    step(1'b0, 1'b1, 1'b0);
    tests++;
    if (busy !== 1'b1 || wr_addr !== 6'd35) begin
      fails++; $display("FAIL flush_pre: got busy=%0b addr=%0d required busy=1 addr=35", busy, wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({data, wr_en, wr_addr, wr_done, busy} !== 36'd0) begin
      fails++; $display("FAIL rst_flush_outputs: got %0h required 0", {data, wr_en, wr_addr, wr_done, busy});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step(1'b0, 1'b0, 1'b0);
    tests++;
    if (done_cyc.size() != 0) begin fails++; $display("FAIL rst_flush_no_done: got %0d required 0", done_cyc.size()); end
  endtask

`ifdef SPI_FRAME_WRITER_PARITY_EN
  task automatic test_parity();
    do_clr();
    send_word(28'h000_0003, 1'b1, 4'h8, 28);
    tests++;
    if (par_err !== 1'b0) begin fails++; $display("FAIL par_before: got %0b required 0", par_err); end
    send_word(28'h000_0003, 1'b0, 4'h8, 32);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (par_err !== 1'b1) begin fails++; $display("FAIL par_set: got %0b required 1", par_err); end
    tests++;
    if (wr_cyc.size() != 1 || wr_dat[0] !== 28'h000_0003) begin
      fails++; $display("FAIL par_write: got %0d writes required 1 of data 3", wr_cyc.size());
    end
    send_word(28'h000_0001, 1'b0, 4'h8, 32);
    tests++;
    if (par_err !== 1'b1) begin fails++; $display("FAIL par_sticky: got %0b required 1", par_err); end
    step(1'b1, 1'b0, 1'b0);
    tests++;
    if (par_err !== 1'b0) begin fails++; $display("FAIL par_start_clear: got %0b required 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_lsb_first();
    test_gapped();
    test_restart();
    test_idle_clr_rst();
`ifdef SPI_FRAME_WRITER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
